// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks the eight channels of the downstream two-level 8:1
// select mux. For each channel it holds the select lines for SETTLE cycles,
// then samples mux_out. After the last channel it presents the eight samples
// as one byte on data and pulses done for one cycle.
// Optional build macro MUX_SCAN_MASK_EN adds ch_mask[7:0]. Masked channels
// are skipped at no cycle cost and read back as 0.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
`ifdef MUX_SCAN_MASK_EN
  input  logic [7:0] ch_mask,
`endif
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       x,
  output logic       busy,
  output logic       done,
  output logic [7:0] data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic [7:0] mask_q, mask_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic [7:0] mask_in;
  logic [3:0] first_ch;
  logic [3:0] next_ch;

`ifdef MUX_SCAN_MASK_EN
  assign mask_in = ch_mask;
`else
  assign mask_in = '0;
`endif

  // Returns {found, ch}. ch is the lowest unmasked channel at or above lo.
  function automatic logic [3:0] find_ch(input logic [7:0] m, input logic [3:0] lo);
    logic       found;
    logic [2:0] ch;
    found = 1'b0;
    ch    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && (4'(i) >= lo) && !m[3'(i)]) begin
        found = 1'b1;
        ch    = 3'(i);
      end
    end
    return {found, ch};
  endfunction

  assign first_ch = find_ch(mask_in, 4'd0);
  assign next_ch  = find_ch(mask_q, {1'b0, ch_q} + 4'd1);

  // State and datapath registers. Every output is taken from one of these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: settle counting, sample capture, abort, and completion.
  // done and data are registered when the FSM leaves DONE, so they become
  // visible together in the following IDLE cycle, when busy has already dropped.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ch_d = '0;
        if (start) begin
          cnt_d   = '0;
          shift_d = '0;
          mask_d  = mask_in;
          if (first_ch[3]) begin
            ch_d    = first_ch[2:0];
            state_d = S_SETTLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          ch_d    = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(SETTLE - 1)) begin
            state_d = S_SAMPLE;
          end
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
          ch_d    = '0;
          cnt_d   = '0;
        end else begin
          shift_d[ch_q] = mux_out;
          if (next_ch[3]) begin
            ch_d    = next_ch[2:0];
            cnt_d   = '0;
            state_d = S_SETTLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        data_d  = shift_q;
        done_d  = 1'b1;
        ch_d    = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign x    = ch_q[2];
  assign s0   = ch_q[1];
  assign s2   = ch_q[1];
  assign s1   = ch_q[0];
  assign s3   = ch_q[0];
  assign busy = busy_q;
  assign done = done_q;
  assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl. A behavioural two-bank mux feeds the DUT.
// Each accepted scan pushes its expected byte and done cycle onto a queue.
// A monitor pops one entry per done pulse and compares it.
module tb_mux_scan_ctrl;
  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       mux_out;
  logic [7:0] ch_mask;
  logic       s0, s1, s2, s3, x, busy, done;
  logic [7:0] data;
  logic [7:0] in_v;
  logic [7:0] last_data;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  int unsigned cyc    = 0;

  typedef struct {
    logic [7:0]  d;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank A (a..d) is selected by s0/s1, bank B (e..h) by s2/s3, and x picks the bank.
  assign mux_out = x ? in_v[{1'b1, s2, s3}] : in_v[{1'b0, s0, s1}];

  mux_scan_ctrl #(.SETTLE(SETTLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .mux_out (mux_out),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask (ch_mask),
`endif
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .s3      (s3),
    .x       (x),
    .busy    (busy),
    .done    (done),
    .data    (data)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("data", 32'(data), 32'(e.d));
        check_eq("done_cycle", cyc, e.at);
        last_data = e.d;
      end
    end
  end

  // Runs one scan from accept through the done cycle.
  // poke: drives a start that must be ignored mid-scan, then start+abort during DONE.
  task automatic scan(input logic [7:0] m, input bit poke, input bit abort_acc);
    int unsigned nact;
    int unsigned fin;
    int unsigned a;
    int unsigned idx;
    int unsigned chs[$];
    logic [7:0]  ed;
    nact = 0;
    for (int k = 0; k < 8; k++) begin
      if (!m[k]) begin
        nact++;
        chs.push_back(k);
      end
    end
    ed  = in_v & ~m;
    fin = nact * (SETTLE + 1) + 1;
    ch_mask = m;
    start   = 1'b1;
    abort   = abort_acc;
    @(posedge clk);
    #1;
    a = cyc;
    sb.push_back('{ed, a + fin});
    start   = 1'b0;
    abort   = 1'b0;
    ch_mask = 8'($urandom);
    for (int unsigned n = 0; n <= fin; n++) begin
      @(negedge clk);
      check_eq("busy", 32'(busy), 32'(n < fin));
      if (n >= SETTLE && ((n - SETTLE) % (SETTLE + 1)) == 0 &&
          ((n - SETTLE) / (SETTLE + 1)) < nact) begin
        idx = (n - SETTLE) / (SETTLE + 1);
        check_eq("sel_a", 32'({x, s0, s1}), chs[idx]);
        check_eq("sel_b", 32'({x, s2, s3}), chs[idx]);
      end
      start = 1'b0;
      abort = 1'b0;
      if (poke && n == 4) start = 1'b1;
      if (poke && n + 1 == fin) begin
        start = 1'b1;
        abort = 1'b1;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned a;
    rst_n     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    ch_mask   = 8'h00;
    in_v      = 8'b1010_0101;
    last_data = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", 32'({s0, s1, s2, s3, x, busy, done, data}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_idle", 32'({s0, s1, s2, s3, x, busy, done, data}), 32'd0);

    scan(8'h00, 1'b0, 1'b0);

    // Abort while channel 3 is settling.
    start = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    start = 1'b0;
    for (int unsigned n = 0; n <= 9; n++) @(negedge clk);
    check_eq("abort_ch", 32'({x, s0, s1}), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_sel", 32'({x, s0, s1, s2, s3}), 32'd0);
    repeat (30) @(negedge clk);
    check_eq("abort_data", 32'(data), 32'(last_data));
    check_eq("abort_len", cyc - a, 32'd40);

    scan(8'h00, 1'b0, 1'b0);
    scan(8'h00, 1'b1, 1'b0);
    in_v = 8'b0111_0110;
    scan(8'h00, 1'b0, 1'b1);
    scan(8'h00, 1'b0, 1'b0);

`ifdef MUX_SCAN_MASK_EN
    in_v = 8'hFF;
    scan(8'hF0, 1'b0, 1'b0);
    scan(8'hFF, 1'b1, 1'b0);
    in_v = 8'b1100_1011;
    scan(8'h5A, 1'b0, 1'b0);
`endif

    // Reset in the middle of a scan clears everything immediately.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid", 32'({s0, s1, s2, s3, x, busy, done, data}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_data = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_mid_idle", 32'({busy, done, data}), 32'd0);

    in_v = 8'b1010_0101;
    scan(8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
